// File: rtl/dtu_link.sv
// dtu_link: parametrised asynchronous-serial link.
//   TX path : FIFO -> framer (start, DATA_W data bits LSB first, optional parity, stop bits).
//   RX path : 2-flop synchroniser -> mid-bit sampling receiver -> held output word with
//             ready/ack handshake, parity/framing error and overrun flags.
//   Bit timing comes from a shared tick divider; one bit = CLK_DIV*OVERSAMPLE clk cycles.
//
// Ports
//   clk, rst            system clock (rising edge), asynchronous active-high reset
//   en                  block enable; low freezes the tick divider and parks both FSMs in IDLE
//   loopback            receiver listens to tx_so instead of rx_si
//   tx_data/tx_valid    word to send, accepted when tx_valid & tx_ready
//   tx_ready            TX FIFO not full
//   tx_so               serial output, idle high
//   tx_busy             frame in progress or FIFO not empty
//   rx_si               serial input (asynchronous)
//   rx_ack              consumer has taken rx_data
//   rx_data/rx_ready    received word, held until rx_ack
//   rx_error            parity or framing error on the held word
//   rx_overrun          a frame completed while rx_ready was high and was dropped
//   rx_busy             receiver not IDLE
//
// TX FSM
//   state     | meaning
//   TX_IDLE   | line high, waits for a tick with the FIFO non-empty, pops the head word
//   TX_START  | start bit (low) for OVERSAMPLE ticks
//   TX_DATA   | DATA_W data bits, LSB first, OVERSAMPLE ticks each
//   TX_PARITY | parity bit for OVERSAMPLE ticks
//   TX_STOP   | line high for STOP_BITS*OVERSAMPLE ticks
//
// RX FSM
//   state     | meaning
//   RX_IDLE   | waits for a falling edge on the synchronised line
//   RX_START  | waits OVERSAMPLE/2 ticks, re-checks the line (high = false start)
//   RX_DATA   | samples DATA_W bits, one every OVERSAMPLE ticks
//   RX_PARITY | samples the parity bit
//   RX_STOP   | samples the first stop bit, then flags completion for one clock
module dtu_link #(
    parameter int DATA_W     = 8,
    parameter int CLK_DIV    = 8,
    parameter int OVERSAMPLE = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              loopback,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_so,
    output logic              tx_busy,
    input  logic              rx_si,
    input  logic              rx_ack,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_ready,
    output logic              rx_error,
    output logic              rx_overrun,
    output logic              rx_busy
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TCNT_W = $clog2(STOP_BITS * OVERSAMPLE) + 1;
    localparam int BCNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [DATA_W-1:0] DATA_MSB = DATA_W'(1) << (DATA_W - 1);

    // ---------------- tick divider ----------------
    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick = en && (div_cnt == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (en) begin
            div_cnt <= (div_cnt == DIV_W'(CLK_DIV - 1)) ? '0 : div_cnt + 1'b1;
        end
    end

    // ---------------- TX FIFO ----------------
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr, rd_ptr;
    logic              fifo_empty, fifo_full, fifo_push, tx_pop;
    logic [DATA_W-1:0] fifo_head;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign fifo_push  = tx_valid && !fifo_full;
    assign fifo_head  = fifo_mem[rd_ptr[PTR_W-1:0]];
    assign tx_ready   = !fifo_full;

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= tx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
            if (tx_pop)    rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // ---------------- TX FSM ----------------
    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    tx_state_t         tx_state;
    logic [DATA_W-1:0] tx_sh, tx_sh_nxt;
    logic              tx_par;
    logic [TCNT_W-1:0] tx_tcnt;
    logic [BCNT_W-1:0] tx_bcnt;

    assign tx_pop    = (tx_state == TX_IDLE) && tick && !fifo_empty;
    assign tx_sh_nxt = tx_sh >> 1;
    assign tx_busy   = (tx_state != TX_IDLE) || !fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_so    <= 1'b1;
            tx_sh    <= '0;
            tx_par   <= 1'b0;
            tx_tcnt  <= '0;
            tx_bcnt  <= '0;
        end else if (!en) begin
            tx_state <= TX_IDLE;
            tx_so    <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    tx_so <= 1'b1;
                    if (tx_pop) begin
                        tx_sh    <= fifo_head;
                        tx_par   <= (PARITY_ODD != 0) ? ~^fifo_head : ^fifo_head;
                        tx_tcnt  <= TCNT_W'(OVERSAMPLE - 1);
                        tx_so    <= 1'b0;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (tick) begin
                        if (tx_tcnt == '0) begin
                            tx_tcnt  <= TCNT_W'(OVERSAMPLE - 1);
                            tx_bcnt  <= BCNT_W'(DATA_W - 1);
                            tx_so    <= tx_sh[0];
                            tx_state <= TX_DATA;
                        end else begin
                            tx_tcnt <= tx_tcnt - 1'b1;
                        end
                    end
                end
                TX_DATA: begin
                    if (tick) begin
                        if (tx_tcnt == '0) begin
                            tx_tcnt <= TCNT_W'(OVERSAMPLE - 1);
                            if (tx_bcnt == '0) begin
                                if (PARITY_EN != 0) begin
                                    tx_so    <= tx_par;
                                    tx_state <= TX_PARITY;
                                end else begin
                                    tx_so    <= 1'b1;
                                    tx_tcnt  <= TCNT_W'(STOP_BITS * OVERSAMPLE - 1);
                                    tx_state <= TX_STOP;
                                end
                            end else begin
                                tx_bcnt <= tx_bcnt - 1'b1;
                                tx_sh   <= tx_sh_nxt;
                                tx_so   <= tx_sh_nxt[0];
                            end
                        end else begin
                            tx_tcnt <= tx_tcnt - 1'b1;
                        end
                    end
                end
                TX_PARITY: begin
                    if (tick) begin
                        if (tx_tcnt == '0) begin
                            tx_so    <= 1'b1;
                            tx_tcnt  <= TCNT_W'(STOP_BITS * OVERSAMPLE - 1);
                            tx_state <= TX_STOP;
                        end else begin
                            tx_tcnt <= tx_tcnt - 1'b1;
                        end
                    end
                end
                TX_STOP: begin
                    if (tick) begin
                        if (tx_tcnt == '0) begin
                            tx_state <= TX_IDLE;
                        end else begin
                            tx_tcnt <= tx_tcnt - 1'b1;
                        end
                    end
                end
                default: begin
                    tx_state <= TX_IDLE;
                    tx_so    <= 1'b1;
                end
            endcase
        end
    end

    // ---------------- RX input conditioning ----------------
    logic [1:0] rx_sync;
    logic       rx_s, rx_prev, rx_fall;

    assign rx_s    = rx_sync[1];
    // Edge (not level) start detection: after a framing error with the line stuck low,
    // the line must go high again before a new start is accepted.
    assign rx_fall = rx_prev && !rx_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], loopback ? tx_so : rx_si};
            rx_prev <= rx_s;
        end
    end

    // ---------------- RX FSM ----------------
    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_t;

    rx_state_t         rx_state;
    logic [DATA_W-1:0] rx_sh;
    logic              rx_par_bit, rx_stop_bit, rx_done;
    logic [TCNT_W-1:0] rx_tcnt;
    logic [BCNT_W-1:0] rx_bcnt;
    logic              rx_par_exp, rx_frame_err;

    assign rx_busy      = (rx_state != RX_IDLE);
    assign rx_par_exp   = (PARITY_ODD != 0) ? ~^rx_sh : ^rx_sh;
    assign rx_frame_err = ((PARITY_EN != 0) && (rx_par_bit != rx_par_exp)) || !rx_stop_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state    <= RX_IDLE;
            rx_sh       <= '0;
            rx_par_bit  <= 1'b0;
            rx_stop_bit <= 1'b1;
            rx_done     <= 1'b0;
            rx_tcnt     <= '0;
            rx_bcnt     <= '0;
        end else begin
            rx_done <= 1'b0;
            if (!en) begin
                rx_state <= RX_IDLE;
            end else begin
                case (rx_state)
                    RX_IDLE: begin
                        if (rx_fall) begin
                            rx_tcnt  <= TCNT_W'(OVERSAMPLE / 2 - 1);
                            rx_state <= RX_START;
                        end
                    end
                    RX_START: begin
                        if (tick) begin
                            if (rx_tcnt == '0) begin
                                if (rx_s) begin
                                    rx_state <= RX_IDLE;
                                end else begin
                                    rx_tcnt  <= TCNT_W'(OVERSAMPLE - 1);
                                    rx_bcnt  <= BCNT_W'(DATA_W - 1);
                                    rx_state <= RX_DATA;
                                end
                            end else begin
                                rx_tcnt <= rx_tcnt - 1'b1;
                            end
                        end
                    end
                    RX_DATA: begin
                        if (tick) begin
                            if (rx_tcnt == '0) begin
                                rx_sh   <= (rx_sh >> 1) | (rx_s ? DATA_MSB : '0);
                                rx_tcnt <= TCNT_W'(OVERSAMPLE - 1);
                                if (rx_bcnt == '0) begin
                                    rx_state <= (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
                                end else begin
                                    rx_bcnt <= rx_bcnt - 1'b1;
                                end
                            end else begin
                                rx_tcnt <= rx_tcnt - 1'b1;
                            end
                        end
                    end
                    RX_PARITY: begin
                        if (tick) begin
                            if (rx_tcnt == '0) begin
                                rx_par_bit <= rx_s;
                                rx_tcnt    <= TCNT_W'(OVERSAMPLE - 1);
                                rx_state   <= RX_STOP;
                            end else begin
                                rx_tcnt <= rx_tcnt - 1'b1;
                            end
                        end
                    end
                    RX_STOP: begin
                        if (tick) begin
                            if (rx_tcnt == '0) begin
                                rx_stop_bit <= rx_s;
                                rx_done     <= 1'b1;
                                rx_state    <= RX_IDLE;
                            end else begin
                                rx_tcnt <= rx_tcnt - 1'b1;
                            end
                        end
                    end
                    default: rx_state <= RX_IDLE;
                endcase
            end
        end
    end

    // ---------------- RX output handshake ----------------
    // An ack landing in the completion cycle frees the holding register for the new word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data    <= '0;
            rx_ready   <= 1'b0;
            rx_error   <= 1'b0;
            rx_overrun <= 1'b0;
        end else if (rx_done) begin
            if (!rx_ready || rx_ack) begin
                rx_data  <= rx_sh;
                rx_ready <= 1'b1;
                rx_error <= rx_frame_err;
            end else begin
                rx_overrun <= 1'b1;
            end
        end else if (rx_ack) begin
            rx_ready   <= 1'b0;
            rx_error   <= 1'b0;
            rx_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dtu_link.sv
// Bench for dtu_link with default parameters (8 data bits, even parity, 1 stop bit,
// 64 clk per bit, 4-entry FIFO). Expected frames and receive results come from a small
// model of the serial format built from the frame rules.
module tb_dtu_link;

    localparam int BIT = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       loopback = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_so, tx_busy;
    logic       rx_si = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_ready, rx_error, rx_overrun, rx_busy;

    int tests_run = 0;
    int tests_failed = 0;

    dtu_link #(
        .DATA_W(8), .CLK_DIV(8), .OVERSAMPLE(8), .PARITY_EN(1),
        .PARITY_ODD(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .loopback(loopback),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_so(tx_so), .tx_busy(tx_busy), .rx_si(rx_si), .rx_ack(rx_ack),
        .rx_data(rx_data), .rx_ready(rx_ready), .rx_error(rx_error),
        .rx_overrun(rx_overrun), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Even parity: the parity bit makes the total number of ones even.
    function automatic logic model_parity(input logic [7:0] w);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(w[i]);
        return (ones % 2 == 1);
    endfunction

    // Frame bit k as it appears on the line: start, d0..d7, parity, stop.
    function automatic logic [10:0] model_frame(input logic [7:0] w);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = w[i];
        f[9]  = model_parity(w);
        f[10] = 1'b1;
        return f;
    endfunction

    // ---------------- stimulus / capture utilities ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] w);
        @(negedge clk);
        tx_data  = w;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
    endtask

    task automatic line_hold(input logic level, input int nbits);
        @(negedge clk);
        rx_si = level;
        repeat (nbits * BIT - 1) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] w, input logic flip_par, input logic stop_v);
        logic [10:0] f;
        f = model_frame(w);
        f[9]  = f[9] ^ flip_par;
        f[10] = stop_v;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            rx_si = f[k];
            repeat (BIT - 1) @(negedge clk);
        end
    endtask

    // Finds the start edge, then samples each bit near its start, middle and end.
    task automatic capture_tx(output logic [10:0] bits, output bit found, output bit stable);
        logic first;
        found  = 1'b0;
        stable = 1'b1;
        bits   = '0;
        first  = 1'b0;
        for (int c = 0; c < 200; c++) begin
            step();
            if (tx_so === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) return;
        for (int k = 0; k < 11; k++) begin
            for (int j = 0; j < BIT; j++) begin
                if (j == 2) first = tx_so;
                if (j == 32) bits[k] = tx_so;
                if ((j == 32 || j == 61) && tx_so !== first) stable = 1'b0;
                step();
            end
        end
    endtask

    task automatic wait_rx_ready(input int max_cyc, output bit got);
        got = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            if (rx_ready === 1'b1) begin
                got = 1'b1;
                break;
            end
            step();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (4) @(negedge clk);
        tests_run++; if (tx_so !== 1'b1) begin tests_failed++; $display("FAIL reset_tx_so: got %b want 1", tx_so); end
        tests_run++; if (tx_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
        tests_run++; if (tx_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_busy: got %b want 0", tx_busy); end
        tests_run++; if (rx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
        tests_run++; if ({rx_ready, rx_error, rx_overrun, rx_busy} !== 4'b0000) begin tests_failed++; $display("FAIL reset_rx_flags: got %b want 0000", {rx_ready, rx_error, rx_overrun, rx_busy}); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_tx_loopback();
        logic [10:0] bits, exp;
        bit found, stable, got;
        loopback = 1'b1;
        exp = model_frame(8'hA9);
        push_word(8'hA9);
        capture_tx(bits, found, stable);
        tests_run++; if (found !== 1'b1) begin tests_failed++; $display("FAIL t1_start_found: got %b want 1", found); end
        tests_run++; if (stable !== 1'b1) begin tests_failed++; $display("FAIL t1_bit_width: got unstable want 64-clk bits"); end
        for (int k = 0; k < 11; k++) begin
            tests_run++; if (bits[k] !== exp[k]) begin tests_failed++; $display("FAIL t1_tx_bit%0d: got %b want %b", k, bits[k], exp[k]); end
        end
        wait_rx_ready(4 * BIT, got);
        tests_run++; if (got !== 1'b1) begin tests_failed++; $display("FAIL t1_rx_ready: got timeout want ready"); end
        tests_run++; if (rx_data !== 8'hA9) begin tests_failed++; $display("FAIL t1_rx_data: got %h want a9", rx_data); end
        tests_run++; if (rx_error !== 1'b0) begin tests_failed++; $display("FAIL t1_rx_error: got %b want 0", rx_error); end
        pulse_ack();
        tests_run++; if (rx_ready !== 1'b0) begin tests_failed++; $display("FAIL t1_ack_clear: got %b want 0", rx_ready); end
        loopback = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [5] = '{8'h77, 8'hAA, 8'h10, 8'hEF, 8'h55};
        loopback = 1'b1;
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_word(words[i]);
            tests_run++; if (tx_ready !== (i < 3)) begin tests_failed++; $display("FAIL t2_tx_ready_after_push%0d: got %b want %b", i, tx_ready, (i < 3)); end
        end
        tests_run++; if ({tx_so, tx_busy} !== 2'b11) begin tests_failed++; $display("FAIL t2_en_low_hold: got so/busy %b want 11", {tx_so, tx_busy}); end
        @(negedge clk);
        en = 1'b1;
        fork
            begin : gap_check
                bit found;
                found = 1'b0;
                for (int c = 0; c < 200; c++) begin
                    step();
                    if (tx_so === 1'b0) begin found = 1'b1; break; end
                end
                tests_run++; if (found !== 1'b1) begin tests_failed++; $display("FAIL t2_first_start: got timeout want start bit"); end
                // Frame of 11 bits plus one idle tick: starts 712 clk apart.
                for (int f = 1; f < 4; f++) begin
                    repeat (11 * BIT + 7) step();
                    tests_run++; if (tx_so !== 1'b1) begin tests_failed++; $display("FAIL t2_idle_before_frame%0d: got %b want 1", f, tx_so); end
                    step();
                    tests_run++; if (tx_so !== 1'b0) begin tests_failed++; $display("FAIL t2_start_of_frame%0d: got %b want 0", f, tx_so); end
                end
            end
            begin : receiver
                bit got;
                for (int i = 0; i < 4; i++) begin
                    wait_rx_ready(14 * BIT, got);
                    tests_run++; if (got !== 1'b1) begin tests_failed++; $display("FAIL t2_rx_ready%0d: got timeout want ready", i); end
                    tests_run++; if ({rx_error, rx_data} !== {1'b0, words[i]}) begin tests_failed++; $display("FAIL t2_rx_word%0d: got err %b data %h want err 0 data %h", i, rx_error, rx_data, words[i]); end
                    pulse_ack();
                end
            end
        join
        repeat (2 * BIT) @(negedge clk);
        tests_run++; if (rx_ready !== 1'b0) begin tests_failed++; $display("FAIL t2_fifth_rejected: got rx_ready %b want 0", rx_ready); end
        tests_run++; if (tx_busy !== 1'b0) begin tests_failed++; $display("FAIL t2_tx_drained: got tx_busy %b want 0", tx_busy); end
        loopback = 1'b0;
    endtask

    task automatic test_parity_error();
        bit got;
        send_frame(8'h3C, 1'b1, 1'b1);
        line_hold(1'b1, 1);
        wait_rx_ready(BIT, got);
        tests_run++; if (got !== 1'b1) begin tests_failed++; $display("FAIL t3_rx_ready: got timeout want ready"); end
        tests_run++; if ({rx_error, rx_data} !== {1'b1, 8'h3C}) begin tests_failed++; $display("FAIL t3_parity_err: got err %b data %h want err 1 data 3c", rx_error, rx_data); end
        pulse_ack();
        tests_run++; if ({rx_ready, rx_error} !== 2'b00) begin tests_failed++; $display("FAIL t3_ack_clear: got %b want 00", {rx_ready, rx_error}); end
    endtask

    task automatic test_framing();
        bit got;
        send_frame(8'h5A, 1'b0, 1'b0);
        line_hold(1'b0, 3);
        tests_run++; if ({rx_ready, rx_error, rx_data} !== {2'b11, 8'h5A}) begin tests_failed++; $display("FAIL t4_framing_err: got rdy %b err %b data %h want rdy 1 err 1 data 5a", rx_ready, rx_error, rx_data); end
        tests_run++; if (rx_busy !== 1'b0) begin tests_failed++; $display("FAIL t4_idle_while_low: got rx_busy %b want 0", rx_busy); end
        pulse_ack();
        line_hold(1'b1, 1);
        tests_run++; if ({rx_ready, rx_overrun} !== 2'b00) begin tests_failed++; $display("FAIL t4_no_bogus_frame: got rdy/ovr %b want 00", {rx_ready, rx_overrun}); end
        send_frame(8'h12, 1'b0, 1'b1);
        line_hold(1'b1, 1);
        wait_rx_ready(BIT, got);
        tests_run++; if ({got, rx_error, rx_data} !== {2'b10, 8'h12}) begin tests_failed++; $display("FAIL t4_recovery: got rdy %b err %b data %h want rdy 1 err 0 data 12", got, rx_error, rx_data); end
        pulse_ack();
    endtask

    task automatic test_overrun();
        send_frame(8'h01, 1'b0, 1'b1);
        line_hold(1'b1, 1);
        send_frame(8'h02, 1'b0, 1'b1);
        line_hold(1'b1, 1);
        tests_run++; if ({rx_ready, rx_overrun, rx_data} !== {2'b11, 8'h01}) begin tests_failed++; $display("FAIL t5_overrun: got rdy %b ovr %b data %h want rdy 1 ovr 1 data 01", rx_ready, rx_overrun, rx_data); end
        pulse_ack();
        tests_run++; if ({rx_ready, rx_error, rx_overrun} !== 3'b000) begin tests_failed++; $display("FAIL t5_ack_clears_overrun: got %b want 000", {rx_ready, rx_error, rx_overrun}); end
        send_frame(8'h01, 1'b0, 1'b1);
        line_hold(1'b1, 1);
        tests_run++; if (rx_ready !== 1'b1) begin tests_failed++; $display("FAIL t5_first_held: got %b want 1", rx_ready); end
        fork
            begin
                send_frame(8'h02, 1'b0, 1'b1);
                line_hold(1'b1, 1);
            end
            begin : ack_at_completion
                bit seen;
                seen = 1'b0;
                for (int c = 0; c < 3 * BIT; c++) begin
                    step();
                    if (rx_busy === 1'b1) begin seen = 1'b1; break; end
                end
                if (seen) begin
                    seen = 1'b0;
                    for (int c = 0; c < 12 * BIT; c++) begin
                        step();
                        if (rx_busy === 1'b0) begin seen = 1'b1; break; end
                    end
                end
                tests_run++; if (seen !== 1'b1) begin tests_failed++; $display("FAIL t5_busy_window: got timeout want busy pulse"); end
                // rx_busy has just dropped: the next edge is the completion cycle.
                rx_ack = 1'b1;
                step();
                rx_ack = 1'b0;
            end
        join
        tests_run++; if ({rx_ready, rx_overrun, rx_error, rx_data} !== {3'b100, 8'h02}) begin tests_failed++; $display("FAIL t5_ack_in_completion: got rdy %b ovr %b err %b data %h want rdy 1 ovr 0 err 0 data 02", rx_ready, rx_overrun, rx_error, rx_data); end
        pulse_ack();
    endtask

    task automatic test_glitch_and_reset();
        bit found;
        @(negedge clk);
        rx_si = 1'b0;
        repeat (8) @(negedge clk);
        tests_run++; if (rx_busy !== 1'b1) begin tests_failed++; $display("FAIL t6_glitch_seen: got rx_busy %b want 1", rx_busy); end
        repeat (8) @(negedge clk);
        rx_si = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        tests_run++; if ({rx_busy, rx_ready} !== 2'b00) begin tests_failed++; $display("FAIL t6_false_start: got busy/rdy %b want 00", {rx_busy, rx_ready}); end

        push_word(8'h80);
        push_word(8'h11);
        push_word(8'h22);
        found = 1'b0;
        for (int c = 0; c < 200; c++) begin
            step();
            if (tx_so === 1'b0) begin found = 1'b1; break; end
        end
        repeat (100) step();
        tests_run++; if ({found, tx_so} !== 2'b10) begin tests_failed++; $display("FAIL t6_mid_frame: got found %b tx_so %b want found 1 tx_so 0", found, tx_so); end
        #2;
        rst = 1'b1;
        #1;
        tests_run++; if ({tx_so, tx_ready, tx_busy} !== 3'b110) begin tests_failed++; $display("FAIL t6_async_reset: got so/rdy/busy %b want 110", {tx_so, tx_ready, tx_busy}); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3 * BIT) @(negedge clk);
        tests_run++; if ({tx_so, tx_busy} !== 2'b10) begin tests_failed++; $display("FAIL t6_fifo_flushed: got so/busy %b want 10", {tx_so, tx_busy}); end
    endtask

    task automatic test_random_loopback();
        logic [7:0]  w;
        logic [10:0] bits;
        bit found, stable, got;
        loopback = 1'b1;
        for (int n = 0; n < 6; n++) begin
            w = 8'($urandom);
            repeat ($urandom_range(0, 40)) @(negedge clk);
            push_word(w);
            capture_tx(bits, found, stable);
            tests_run++; if ({found, stable, bits} !== {2'b11, model_frame(w)}) begin tests_failed++; $display("FAIL rand_tx_frame%0d: got found %b stable %b bits %b want 1 1 %b", n, found, stable, bits, model_frame(w)); end
            wait_rx_ready(4 * BIT, got);
            tests_run++; if ({got, rx_error, rx_data} !== {2'b10, w}) begin tests_failed++; $display("FAIL rand_loop_rx%0d: got rdy %b err %b data %h want 1 0 %h", n, got, rx_error, rx_data, w); end
            pulse_ack();
        end
        loopback = 1'b0;
    endtask

    task automatic test_random_rx();
        logic [7:0] w;
        logic flip, stop_v, exp_err;
        bit got;
        for (int n = 0; n < 6; n++) begin
            w       = 8'($urandom);
            flip    = ($urandom_range(0, 3) == 0);
            stop_v  = ($urandom_range(0, 3) != 0);
            exp_err = flip | !stop_v;
            send_frame(w, flip, stop_v);
            line_hold(1'b1, 1);
            wait_rx_ready(BIT, got);
            tests_run++; if ({got, rx_error, rx_data} !== {1'b1, exp_err, w}) begin tests_failed++; $display("FAIL rand_rx%0d: got rdy %b err %b data %h want 1 %b %h", n, got, rx_error, rx_data, exp_err, w); end
            pulse_ack();
            tests_run++; if ({rx_ready, rx_error, rx_overrun} !== 3'b000) begin tests_failed++; $display("FAIL rand_rx_ack%0d: got %b want 000", n, {rx_ready, rx_error, rx_overrun}); end
        end
    endtask

    initial begin
        test_reset();
        test_tx_loopback();
        test_back_to_back();
        test_parity_error();
        test_framing();
        test_overrun();
        test_glitch_and_reset();
        test_random_loopback();
        test_random_rx();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded 5 ms, %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "watchdog");
    end

endmodule
